// File: rtl/toy_mem_responder.sv
// Word-addressed memory responder for the RISC_TOY instruction and data buses.
// Zero-fills after reset, then serves fetches, loads, stores and bench preloads.
module toy_mem_responder #(
    parameter int unsigned AW     = 10,
    parameter bit          CLR_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        IREQ,
    input  logic [29:0] IADDR,
    output logic [31:0] INSTR,
    input  logic        DREQ,
    input  logic        DRW,
    input  logic [29:0] DADDR,
    input  logic [31:0] DWDATA,
    output logic [31:0] DRDATA,
    input  logic        PLEN,
    input  logic [29:0] PLADDR,
    input  logic [31:0] PLDATA,
    output logic        PLACK,
    output logic        READY,
    output logic        ERR
);

    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t         r_state;
    logic [AW-1:0]  r_cnt;
    logic           r_ready;
    logic           r_err;
    logic [31:0]    r_instr;
    logic [31:0]    r_drdata;
    logic [31:0]    r_mem [DEPTH];

    logic           w_clear;
    logic           w_core_wr;
    logic           w_core_rd;
    logic           w_plack;
    logic           w_i_oor;
    logic           w_d_oor;
    logic           w_p_oor;
    logic           w_err_set;
    logic           w_we;
    logic [AW-1:0]  w_waddr;
    logic [31:0]    w_wdata;

    // Address decode and request qualification
    always_comb begin
        w_clear   = (r_state == ST_CLEAR);
        w_core_wr = DREQ & DRW;
        w_core_rd = DREQ & ~DRW;
        w_plack   = r_ready & PLEN & ~w_core_wr;
        w_i_oor   = (IADDR  >> AW) != 30'd0;
        w_d_oor   = (DADDR  >> AW) != 30'd0;
        w_p_oor   = (PLADDR >> AW) != 30'd0;
        w_err_set = (IREQ & w_i_oor) | (DREQ & w_d_oor) | (w_plack & w_p_oor)
                  | (w_clear & w_core_wr);
    end

    // Single write port: clear sweep, then core store, then preload
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (w_clear) begin
            w_we    = 1'b1;
            w_waddr = r_cnt;
        end else if (w_core_wr) begin
            w_we    = ~w_d_oor;
            w_waddr = DADDR[AW-1:0];
            w_wdata = DWDATA;
        end else if (w_plack) begin
            w_we    = ~w_p_oor;
            w_waddr = PLADDR[AW-1:0];
            w_wdata = PLDATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Control FSM plus registered read ports (reads see pre-write contents)
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state  <= CLR_EN ? ST_CLEAR : ST_RUN;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
            r_instr  <= 32'd0;
            r_drdata <= 32'd0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= AW'(r_cnt + 1'b1);
                    if (r_cnt == AW'(DEPTH - 1)) begin
                        r_state <= ST_RUN;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                end
            endcase

            if (IREQ) begin
                r_instr <= (w_clear | w_i_oor) ? 32'd0 : r_mem[IADDR[AW-1:0]];
            end
            if (w_core_rd) begin
                r_drdata <= (w_clear | w_d_oor) ? 32'd0 : r_mem[DADDR[AW-1:0]];
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign INSTR  = r_instr;
    assign DRDATA = r_drdata;
    assign PLACK  = w_plack;
    assign READY  = r_ready;
    assign ERR    = r_err;

endmodule

// File: doc/toy_mem_responder.md
Name: toy_mem_responder

Overview:
- Memory-side responder for the RISC_TOY core's instruction and data bus interfaces.
- Serves instruction fetches (IREQ/IADDR → INSTR) and data loads/stores (DREQ/DRW/DADDR/DWDATA → DRDATA) from one word-addressed storage array.
- Returns read data with one-cycle registered latency, which matches when the core samples it.
- After reset it zero-fills the array, then accepts bench preload writes and core traffic.

Parameters:
AW, 10, word-address width actually decoded; DEPTH = 2^AW 32-bit words
CLR_EN, 1, 1 = zero-fill the array after reset; 0 = go straight to RUN (contents undefined)

Ports:
CLK  in  1  clock, rising edge
RSTN  in  1  asynchronous active-low reset
IREQ  in  1  instruction read request, active high
IADDR  in  30  instruction word address
INSTR  out  32  instruction read data
DREQ  in  1  data request, active high
DRW  in  1  1 = write (store), 0 = read (load); meaningful only when DREQ=1
DADDR  in  30  data word address
DWDATA  in  32  store data
DRDATA  out  32  load data
PLEN  in  1  preload write request
PLADDR  in  30  preload word address
PLDATA  in  32  preload data
PLACK  out  1  preload write accepted this cycle (combinational)
READY  out  1  high in RUN state
ERR  out  1  sticky access-error flag

Behaviour:
- Reset is asynchronous on RSTN low. It forces INSTR=0, DRDATA=0, READY=0, ERR=0, clear counter=0, and state=CLEAR (or RUN if CLR_EN=0). Array contents are not reset.
- Reset asserted mid-CLEAR or mid-RUN aborts the operation and restarts from the reset state.
- FSM CLEAR:
  - Writes 0 to array[cnt] every cycle, with cnt incrementing from 0.
  - After writing DEPTH-1 it moves to RUN on the same edge. CLEAR lasts exactly DEPTH cycles.
  - READY=0 and PLACK=0 in CLEAR.
  - Core reads in CLEAR return 0 and do not set ERR.
  - Core writes (DREQ & DRW) in CLEAR are dropped and set ERR.
- FSM RUN: terminal state until reset. READY=1.
- Range check: an address is out of range when any bit [29:AW] is nonzero.
- Instruction reads:
  - On an edge with IREQ=1, INSTR <= array[IADDR] (0 if out of range). Data is valid the cycle after the request.
  - With IREQ=0, INSTR holds its value (core stalls rely on this).
- Data reads (DREQ=1, DRW=0): DRDATA <= array[DADDR] (0 if out of range). With DREQ=0 or DRW=1, DRDATA holds.
- Data writes (DREQ=1, DRW=1): array[DADDR] <= DWDATA at the edge. An out-of-range write is dropped.
- Preload: PLACK = READY & PLEN & ~(DREQ & DRW). When PLACK=1, array[PLADDR] <= PLDATA. A core store in the same cycle wins and the preload must be retried.
- Same-address collisions:
  - An instruction read in the same cycle as a data or preload write to that address returns the OLD data (read-before-write).
  - A data read issued the cycle after a write returns the new data.
- ERR is set by:
  - any out-of-range access with IREQ, DREQ or PLACK active;
  - any core write during CLEAR.
  ERR is cleared only by reset.
- INSTR and DRDATA are fully registered. There is no combinational path from any input to INSTR or DRDATA.

Test Plan:
- Reset/clear: AW=4, pulse RSTN low, then hold high → READY=0 for exactly 16 cycles, then 1. Reading all 16 words returns 0x00000000 and ERR=0.
- Preload and fetch: preload addr 3 = 0xA5A5_0003, then IREQ=1 with IADDR=3 → INSTR=0xA5A50003 one cycle later. With IREQ=0 for the next 3 cycles, INSTR holds that value.
- Store then load:
  - DREQ=1, DRW=1, DADDR=5, DWDATA=0x1234_5678, then next cycle DRW=0, DADDR=5 → DRDATA=0x12345678 on the following cycle.
  - A simultaneous PLEN=1 to address 6 during the store cycle gives PLACK=0, and address 6 stays unchanged.
- Collision: instruction read of address 7 (old value 0x11) in the same cycle as a store of 0x22 to address 7 → INSTR=0x11; a fetch on the next cycle gives INSTR=0x22.
- Errors:
  - With AW=4, DADDR=16 read → DRDATA=0 and ERR=1, and ERR stays 1.
  - Separately, a store during CLEAR → ERR=1 and the target word still reads 0 after CLEAR.
- Reset mid-CLEAR: assert RSTN low at clear cycle 8 → counter restarts at 0, and READY rises 16 cycles after RSTN is released.
